// File: rtl/rvc_aligner.sv
// rtl/rvc_aligner.sv - halfword realignment buffer between fetch and decode
// Splits aligned fetch words into a 4-entry halfword queue and emits whole RV32IC instructions.
module rvc_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_word,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c,
  input  logic        dec_ready
);

  logic [15:0] q_q [4];
  logic [15:0] q_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic        skip_low_q, skip_low_d;

  logic        is_c;
  logic [2:0]  need;
  logic [2:0]  base;
  logic        deq;
  logic        enq;

  assign is_c        = q_q[0][1:0] != 2'b11;
  assign need        = is_c ? 3'd1 : 3'd2;
  assign instr_valid = (cnt_q >= need) & ~flush;
  // Readiness looks at the current count only, so a full queue stalls fetch for a cycle.
  assign fetch_ready = (cnt_q <= 3'd2) & ~flush;
  assign deq         = instr_valid & dec_ready;
  assign enq         = fetch_valid & fetch_ready;
  assign base        = deq ? (cnt_q - need) : cnt_q;

  assign instr      = is_c ? {16'h0, q_q[0]} : {q_q[1], q_q[0]};
  assign instr_pc   = head_pc_q;
  assign instr_is_c = is_c;

  always_comb begin
    q_d        = q_q;
    cnt_d      = cnt_q;
    head_pc_d  = head_pc_q;
    skip_low_d = skip_low_q;
    if (flush) begin
      cnt_d      = 3'd0;
      head_pc_d  = {flush_pc[31:1], 1'b0};
      skip_low_d = flush_pc[1];
    end else begin
      if (deq) begin
        if (is_c) begin
          q_d[0] = q_q[1];
          q_d[1] = q_q[2];
          q_d[2] = q_q[3];
          q_d[3] = 16'h0;
        end else begin
          q_d[0] = q_q[2];
          q_d[1] = q_q[3];
          q_d[2] = 16'h0;
          q_d[3] = 16'h0;
        end
        head_pc_d = head_pc_q + {28'h0, need, 1'b0};
      end
      // Append after the shift; base never exceeds 2 when enq is possible.
      if (enq) begin
        for (int i = 0; i < 4; i++) begin
          if (skip_low_q) begin
            if (3'(i) == base) q_d[i] = fetch_word[31:16];
          end else begin
            if (3'(i) == base) q_d[i] = fetch_word[15:0];
            else if (3'(i) == base + 3'd1) q_d[i] = fetch_word[31:16];
          end
        end
        skip_low_d = 1'b0;
      end
      cnt_d = base + (enq ? (skip_low_q ? 3'd1 : 3'd2) : 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= '{default: 16'h0};
      cnt_q      <= 3'd0;
      head_pc_q  <= RESET_PC;
      skip_low_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      head_pc_q  <= head_pc_d;
      skip_low_q <= skip_low_d;
    end
  end

endmodule

// File: tb/tb_rvc_aligner.sv
// tb/tb_rvc_aligner.sv - self-checking bench for rvc_aligner
// Two instances share stimulus; the second uses a wrapping reset pc.
module tb_rvc_aligner;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, flush, dec_ready;
  logic [31:0] fetch_word, flush_pc;
  logic        fetch_ready, instr_valid, instr_is_c;
  logic [31:0] instr, instr_pc;
  logic        w_fetch_ready, w_instr_valid, w_instr_is_c;
  logic [31:0] w_instr, w_instr_pc;

  always #5 clk = ~clk;

  rvc_aligner dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_word(fetch_word),
    .fetch_ready(fetch_ready), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_is_c(instr_is_c), .dec_ready(dec_ready)
  );

  rvc_aligner #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_word(fetch_word),
    .fetch_ready(w_fetch_ready), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_is_c(w_instr_is_c), .dec_ready(dec_ready)
  );

  typedef struct {
    logic [31:0] i;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          n;
    exp_t        e0;
    exp_t        e1;
  } vec_t;

  exp_t sb[$];
  exp_t sbw[$];
  bit   w_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vt[6];

  function automatic exp_t ex(input logic [31:0] i, input logic [31:0] pc, input logic c);
    exp_t e;
    e.i = i;
    e.pc = pc;
    e.c = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && dec_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual=%h expected=none", instr);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.i);
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_is_c", {31'h0, instr_is_c}, {31'h0, e.c});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (w_en && !reset && w_instr_valid && dec_ready) begin
      if (sbw.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w_unexpected_instr actual=%h expected=none", w_instr);
      end else begin
        e = sbw.pop_front();
        chk("w_instr", w_instr, e.i);
        chk("w_instr_pc", w_instr_pc, e.pc);
        chk("w_instr_is_c", {31'h0, w_instr_is_c}, {31'h0, e.c});
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int t = 0;
    fetch_valid = 1'b1;
    fetch_word  = w;
    @(negedge clk);
    while (!fetch_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL send_timeout actual=%0d expected=<50 cycles", t);
    end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || sbw.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0 || sbw.size() != 0) begin
      errors++;
      $display("FAIL drain_%s actual=%0d expected=0 pending", name, sb.size() + sbw.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{32'h0050_0093, 1, ex(32'h0050_0093, 32'h00, 1'b0), ex(32'h0, 32'h0, 1'b0)};
    vt[1] = '{32'h00A0_0113, 1, ex(32'h00A0_0113, 32'h04, 1'b0), ex(32'h0, 32'h0, 1'b0)};
    vt[2] = '{32'h0093_4501, 1, ex(32'h0000_4501, 32'h08, 1'b1), ex(32'h0, 32'h0, 1'b0)};
    vt[3] = '{32'h0000_0050, 2, ex(32'h0050_0093, 32'h0A, 1'b0), ex(32'h0000_0000, 32'h0E, 1'b1)};
    vt[4] = '{32'h4585_4501, 2, ex(32'h0000_4501, 32'h10, 1'b1), ex(32'h0000_4585, 32'h12, 1'b1)};
    vt[5] = '{32'h0001_0001, 2, ex(32'h0000_0001, 32'h14, 1'b1), ex(32'h0000_0001, 32'h16, 1'b1)};

    reset = 1'b1; fetch_valid = 1'b0; fetch_word = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; dec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_is_c", {31'h0, instr_is_c}, 32'h1);
    chk("rst_w_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) begin
      sb.push_back(vt[k].e0);
      if (vt[k].n > 1) sb.push_back(vt[k].e1);
      send(vt[k].word);
    end
    drain("stream");

    // Decode stall: four compressed instructions fill the queue.
    dec_ready = 1'b0;
    sb.push_back(ex(32'h4501, 32'h18, 1'b1));
    sb.push_back(ex(32'h4511, 32'h1A, 1'b1));
    sb.push_back(ex(32'h4521, 32'h1C, 1'b1));
    sb.push_back(ex(32'h4531, 32'h1E, 1'b1));
    send(32'h4511_4501);
    send(32'h4531_4521);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_fetch_ready", {31'h0, fetch_ready}, 32'h0);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_instr", instr, 32'h4501);
      chk("stall_pc", instr_pc, 32'h18);
    end
    @(posedge clk);
    #1 dec_ready = 1'b1;
    drain("stall");

    // Misaligned flush with a same-cycle fetch word that must be dropped.
    flush = 1'b1; flush_pc = 32'h103; fetch_valid = 1'b1; fetch_word = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("flush_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0; fetch_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("post_flush_pc", instr_pc, 32'h102);
    chk("post_flush_ready", {31'h0, fetch_ready}, 32'h1);
    @(posedge clk);
    #1;
    sb.push_back(ex(32'h4585, 32'h102, 1'b1));
    send(32'h4585_1234);
    drain("misaligned");

    // Pending straddle halfword discarded by a flush.
    sb.push_back(ex(32'h4501, 32'h104, 1'b1));
    send(32'h0093_4501);
    drain("straddle");
    @(negedge clk);
    chk("straddle_wait_valid", {31'h0, instr_valid}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b1; flush_pc = 32'h200;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("straddle_flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("straddle_flush_pc", instr_pc, 32'h200);
    @(posedge clk);
    #1;
    sb.push_back(ex(32'h00A0_0113, 32'h200, 1'b0));
    send(32'h00A0_0113);
    drain("after_straddle");

    // Flush masks a valid head and blocks its dequeue.
    dec_ready = 1'b0;
    send(32'h4511_4501);
    @(negedge clk);
    chk("pre_flush_valid", {31'h0, instr_valid}, 32'h1);
    @(posedge clk);
    #1 flush = 1'b1; flush_pc = 32'h300; dec_ready = 1'b1;
    @(negedge clk);
    chk("flush_gates_valid", {31'h0, instr_valid}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("flush_drop_pc", instr_pc, 32'h300);
    @(posedge clk);
    #1;

    // Wrap-around from RESET_PC = 0xFFFFFFFC.
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; w_en = 1'b1;
    @(negedge clk);
    chk("wrap_rst_pc", w_instr_pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    sb.push_back(ex(32'h0050_0093, 32'h0, 1'b0));
    sb.push_back(ex(32'h4501, 32'h4, 1'b1));
    sb.push_back(ex(32'h0, 32'h6, 1'b1));
    sbw.push_back(ex(32'h0050_0093, 32'hFFFF_FFFC, 1'b0));
    sbw.push_back(ex(32'h4501, 32'h0, 1'b1));
    sbw.push_back(ex(32'h0, 32'h2, 1'b1));
    send(32'h0050_0093);
    send(32'h0000_4501);
    drain("wrap");

    // Reset mid-stream drops buffered halfwords.
    dec_ready = 1'b0;
    send(32'h4511_4501);
    @(negedge clk);
    chk("mid_valid", {31'h0, instr_valid}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_w_valid", {31'h0, w_instr_valid}, 32'h0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    chk("mid_rst_w_pc", w_instr_pc, 32'hFFFF_FFFC);
    chk("mid_rst_ready", {31'h0, fetch_ready}, 32'h1);
    @(posedge clk);
    #1 dec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'h0);
    chk("sbw_empty", sbw.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvc_aligner.md
# rvc_aligner

Halfword realignment buffer between instruction fetch and decode for the RV32IC core. It accepts 32-bit aligned fetch words and splits them into a halfword queue. It emits one whole instruction per handshake: a 16-bit compressed one, or a 32-bit one that may straddle two fetch words. It back-pressures fetch through `fetch_ready`, and on a redirect it discards buffered halfwords and restarts at a halfword-aligned target.

## Interface
- `RESET_PC`, default 32'h0: pc of the head instruction after reset.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `fetch_valid` input 1: `fetch_word` is valid this cycle.
- `fetch_word` input 32: word at the aligned address of the current fetch pc; the low halfword is the lower address.
- `fetch_ready` output 1: the buffer can accept a word this cycle; fetch stalls when low.
- `flush` input 1: redirect (jump or branch taken).
- `flush_pc` input 32: redirect target; bit 0 is ignored.
- `instr_valid` output 1: a complete instruction is at the head.
- `instr` output 32: `{16'h0, h0}` if compressed, else `{h1, h0}`.
- `instr_pc` output 32: address of the head instruction.
- `instr_is_c` output 1: the head is compressed, i.e. `h0[1:0] != 2'b11`.
- `dec_ready` input 1: decode consumes the head this cycle.

## Operation
- **Storage.** Queue of 4 halfword registers `q[0..3]` plus `cnt` (0..4). Head is `h0 = q[0]`, `h1 = q[1]`. Also holds registers `head_pc` and `skip_low`.
- **Need.** `need = 1` if `h0[1:0] != 2'b11`, else 2.
- **Output valid.** `instr_valid = (cnt >= need) & ~flush`. When `cnt == 0`, `instr_is_c` and `instr` are don't-care, but must not be X after reset (the queue resets to 0).
- **Dequeue.** `deq = instr_valid & dec_ready`.
  - Shift the queue down by `need`.
  - `head_pc += 2*need`, with 32-bit wrap-around.
- **Enqueue.**
  - `fetch_ready = (cnt <= 2) & ~flush`, computed from the current `cnt` only; a same-cycle dequeue is not credited.
  - `enq = fetch_valid & fetch_ready`.
  - If `skip_low`: append only `fetch_word[31:16]` and clear `skip_low`.
  - Else: append the low then the high halfword.
- **Simultaneous enq and deq.** Shift first, then append at index `cnt - need`. The next count is `cnt - need*deq + (skip_low ? 1 : 2)*enq`. It never exceeds 4.
- **Flush has priority over everything.**
  - Next cycle: `cnt = 0`, `head_pc = {flush_pc[31:1], 1'b0}`, `skip_low = flush_pc[1]`.
  - Any same-cycle `fetch_valid` word is discarded.
  - No dequeue occurs in the flush cycle.
- **Reset.** Next cycle: `cnt = 0`, `q = 0`, `head_pc = RESET_PC`, `skip_low = 0`.
  - Outputs after reset: `instr_valid = 0`, `fetch_ready = 1`, `instr_pc = RESET_PC`, `instr = 0`.
  - `instr_is_c = 1`, because `q[0] = 0` decodes as compressed.
  - Reset mid-operation drops all buffered halfwords.
- **Illegal encodings.** Halfword 0x0000 (illegal compressed) is passed through as compressed; decode flags it.

## Timing
- All state updates on the `posedge clk`. Outputs are combinational from registers, except that `instr_valid` and `fetch_ready` are also gated by `flush`.
- Latency:
  - A word accepted in cycle N makes its instruction visible in cycle N+1.
  - A straddling 32-bit instruction becomes valid the cycle after its second word is accepted.
- Throughput: one instruction per cycle while `dec_ready = 1` and fetch supplies words. Sustained all-compressed code back-pressures fetch every other cycle.
- The first word after a flush is accepted no earlier than the cycle after the flush.
- Holding rule: while `instr_valid & ~dec_ready`, `instr`, `instr_pc` and `instr_is_c` stay stable, unless a flush occurs.

## Test plan
- **Reset, then two 32-bit instructions.** Words 0x00500093, 0x00A00113 with `dec_ready = 1` → `instr` 0x00500093 at pc 0x0, then 0x00A00113 at pc 0x4, `instr_is_c = 0`.
- **Mixed stream.** Word 0x00934501 = {32-bit low half 0x0093, C.LI 0x4501}, then word 0x00000050 → first `instr` 0x00004501 at pc 0x0 with `instr_is_c = 1`, then straddling `instr` 0x00500093 at pc 0x2.
- **Decode stall.** Hold `dec_ready = 0` while streaming four 16-bit instructions → `fetch_ready` drops to 0 once `cnt > 2`; outputs hold; no halfword is lost or duplicated after release.
- **Misaligned flush.** `flush = 1`, `flush_pc = 0x102`, then word 0x4585xxxx → single `instr` 0x00004585 at pc 0x102; the low halfword is discarded.
- **Flush with a pending straddle.** `cnt = 1` holding 0x0093, then flush to 0x200 → no `instr_valid` for the stale halfword; the next `instr_pc` is 0x200.
- **Wrap and reset.** `RESET_PC = 32'hFFFFFFFC`: a 32-bit instruction, then a compressed one, gives `instr_pc` 0xFFFFFFFC then 0x00000000. Asserting reset mid-stream → next cycle `instr_valid = 0`, `instr_pc = RESET_PC`.
